// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings and helpers for the data-memory access unit.
// Size codes, FSM state encoding and the per-lane byte mask.
package dmem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  // Lanes touched by an access; a misaligned half at offset 3 truncates, but is rejected upstream.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_access_unit_load_align.sv
// Right-aligns a bank read word by byte offset and sign/zero-extends it by access size.
// Purely combinational; used in the cycle the banks present their registered read data.
module dmem_load_align
  import dmem_access_unit_pkg::*;
(
  input  logic [31:0] q_dat,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = q_dat >> {off, 3'b000};
    case (size)
      SZ_BYTE: rdata = unsigned_ld ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata = unsigned_ld ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store front end driving four byte-wide banks; one request in flight at a time.
// Store response 1 cycle after accept, load response 2 cycles after; responses hold until rsp_ready.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int BANK_AW = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [3:0]         bank_ceb,
  output logic               bank_web,
  output logic [3:0]         bank_we,
  output logic [BANK_AW-1:0] bank_addr,
  output logic [31:0]        bank_wdata,
  input  logic [31:0]        bank_q
);

  state_e      state_q, state_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;

  logic        accept;
  logic        bad_req;
  logic [3:0]  mask;
  logic [31:0] load_data;

  // Gated by resetn so nothing can be accepted on the reset edge itself.
  assign req_ready = (state_q == ST_IDLE) && resetn;
  assign accept    = req_valid && req_ready;
  assign mask      = lane_mask(req_size, req_addr[1:0]);

  always_comb begin
    bad_req = 1'b0;
    case (req_size)
      SZ_HALF: bad_req = req_addr[0];
      SZ_WORD: bad_req = (req_addr[1:0] != 2'b00);
      SZ_RSVD: bad_req = 1'b1;
      default: bad_req = 1'b0;
    endcase
  end

  dmem_load_align u_align (
    .q_dat       (bank_q),
    .off         (off_q),
    .size        (size_q),
    .unsigned_ld (uns_q),
    .rdata       (load_data)
  );

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    bank_ceb    = 4'hF;
    bank_web    = 1'b1;
    bank_we     = 4'h0;
    bank_addr   = '0;
    bank_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          off_d       = req_addr[1:0];
          size_d      = req_size;
          uns_d       = req_unsigned;
          rsp_rdata_d = '0;
          rsp_err_d   = bad_req;
          if (bad_req) begin
            state_d = ST_RESP;
          end else if (req_we) begin
            bank_web  = 1'b0;
            bank_we   = mask;
            bank_addr = req_addr[ADDR_W-1:2];
            case (req_size)
              SZ_BYTE: bank_wdata = {4{req_wdata[7:0]}};
              SZ_HALF: bank_wdata = {2{req_wdata[15:0]}};
              default: bank_wdata = req_wdata;
            endcase
            state_d = ST_RESP;
          end else begin
            bank_ceb  = ~mask;
            bank_addr = req_addr[ADDR_W-1:2];
            state_d   = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        rsp_rdata_d = load_data;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: byte-array memory model with a per-cycle compare process,
// plus directed requests carrying hand-computed expectations.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  bank_ceb;
  logic        bank_web;
  logic [3:0]  bank_we;
  logic [9:0]  bank_addr;
  logic [31:0] bank_wdata;
  logic [31:0] bank_q = '0;

  int tests = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.ADDR_W(12), .BANK_AW(10)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bank_ceb(bank_ceb), .bank_web(bank_web), .bank_we(bank_we),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_q(bank_q)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Four byte-wide banks with registered read data.
  logic [7:0] bank_mem [4][1024];
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (!bank_web && bank_we[n]) bank_mem[n][bank_addr] <= bank_wdata[8*n +: 8];
      if (bank_web && !bank_ceb[n]) bank_q[8*n +: 8] <= bank_mem[n][bank_addr];
    end
  end

  // Reference model: flat byte memory and a single outstanding expected response.
  logic [7:0]  mem_model [4096];
  int          cyc = 0;
  logic        pending = 1'b0;
  int          due = 0;
  logic [31:0] exp_d = '0;
  logic        exp_e = 1'b0;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    int nb, a;
    logic [31:0] v;
    if (!resetn) begin
      pending = 1'b0;
    end else if (pending && cyc >= due) begin
      if (rsp_ready) pending = 1'b0;
    end else if (!pending && req_valid) begin
      nb = 1 << req_size;
      a  = int'(req_addr);
      pending = 1'b1;
      if (req_size == 2'd3 || (a % nb) != 0) begin
        exp_d = 0; exp_e = 1'b1; due = cyc + 1;
      end else if (req_we) begin
        for (int i = 0; i < nb; i++) mem_model[a + i] = req_wdata[8*i +: 8];
        exp_d = 0; exp_e = 1'b0; due = cyc + 1;
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v | (32'(mem_model[a + i]) << (8 * i));
        if (!req_unsigned && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        exp_d = v; exp_e = 1'b0; due = cyc + 2;
      end
    end
    cyc++;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic exp_vld, acc, ok, chk_wd;
    logic [3:0] m, e_ceb, e_we;
    logic e_web;
    logic [31:0] e_wd, e_addr;
    int nb, off;
    if (chk_en) begin
      exp_vld = pending && (cyc >= due);
      chk("req_ready", 32'(req_ready), 32'(resetn && !pending));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
      if (exp_vld) begin
        chk("rsp_rdata", rsp_rdata, exp_d);
        chk("rsp_err", 32'(rsp_err), 32'(exp_e));
      end
      nb  = 1 << req_size;
      off = int'(req_addr[1:0]);
      acc = req_valid && resetn && !pending;
      ok  = (req_size != 2'd3) && ((int'(req_addr) % nb) == 0);
      e_ceb = 4'hF; e_web = 1'b1; e_we = 4'h0; e_addr = 0; e_wd = 0; chk_wd = 1'b1;
      if (acc && ok) begin
        m = 4'h0;
        for (int n = 0; n < 4; n++) if (n >= off && n < off + nb) m[n] = 1'b1;
        e_addr = 32'(req_addr) >> 2;
        if (req_we) begin
          e_web = 1'b0; e_we = m;
          for (int n = 0; n < 4; n++) e_wd[8*n +: 8] = req_wdata[8*(n % nb) +: 8];
        end else begin
          e_ceb = ~m; chk_wd = 1'b0;
        end
      end
      chk("bank_ceb", 32'(bank_ceb), 32'(e_ceb));
      chk("bank_web", 32'(bank_web), 32'(e_web));
      chk("bank_we", 32'(bank_we), 32'(e_we));
      chk("bank_addr", 32'(bank_addr), e_addr);
      if (chk_wd) chk("bank_wdata", bank_wdata, e_wd);
    end
  end

  logic [3:0] cap_we, cap_ceb;
  logic [9:0] cap_addr;

  // Issue one request at posedge+1 and collect its response; ends at posedge+1.
  task automatic do_req(input string nm, input logic we, input logic [11:0] a,
                        input logic [1:0] sz, input logic u, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] ed, input logic ee,
                        input int hold);
    int lat;
    logic [31:0] d0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    @(negedge clk);
    cap_we = bank_we; cap_ceb = bank_ceb; cap_addr = bank_addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_data"}, rsp_rdata, ed);
    chk({nm, "_err"}, 32'(rsp_err), 32'(ee));
    d0 = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      #1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010; req_size = 2'd2;
      @(posedge clk); @(negedge clk);
      chk({nm, "_hold_data"}, rsp_rdata, d0);
      chk({nm, "_hold_vld"}, 32'(rsp_valid), 32'd1);
      chk({nm, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_done"}, 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem_model[i] = 8'h00;
    for (int n = 0; n < 4; n++) for (int i = 0; i < 1024; i++) bank_mem[n][i] = 8'h00;

    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_ceb", 32'(bank_ceb), 32'hF);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    do_req("st_word", 1'b1, 12'h010, 2'd2, 1'b0, 32'hDEADBEEF, 1, 32'h0, 1'b0, 0);
    chk("st_word_we", 32'(cap_we), 32'hF);
    chk("st_word_addr", 32'(cap_addr), 32'd4);
    do_req("ld_word", 1'b0, 12'h010, 2'd2, 1'b0, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);
    chk("ld_word_ceb", 32'(cap_ceb), 32'h0);
    do_req("ld_byte_s", 1'b0, 12'h013, 2'd0, 1'b0, 32'h0, 2, 32'hFFFFFFDE, 1'b0, 0);
    chk("ld_byte_ceb", 32'(cap_ceb), 32'h7);
    do_req("ld_byte_u", 1'b0, 12'h013, 2'd0, 1'b1, 32'h0, 2, 32'h000000DE, 1'b0, 0);
    do_req("ld_half_s", 1'b0, 12'h012, 2'd1, 1'b0, 32'h0, 2, 32'hFFFFDEAD, 1'b0, 0);
    do_req("ld_half_u", 1'b0, 12'h010, 2'd1, 1'b1, 32'h0, 2, 32'h0000BEEF, 1'b0, 0);
    do_req("st_byte", 1'b1, 12'h021, 2'd0, 1'b0, 32'h0000005A, 1, 32'h0, 1'b0, 0);
    chk("st_byte_we", 32'(cap_we), 32'h2);
    do_req("ld_word2", 1'b0, 12'h020, 2'd2, 1'b0, 32'h0, 2, 32'h00005A00, 1'b0, 0);
    do_req("st_half", 1'b1, 12'h032, 2'd1, 1'b0, 32'h00008001, 1, 32'h0, 1'b0, 0);
    chk("st_half_we", 32'(cap_we), 32'hC);
    do_req("ld_half3", 1'b0, 12'h032, 2'd1, 1'b0, 32'h0, 2, 32'hFFFF8001, 1'b0, 0);
    do_req("mis_half", 1'b0, 12'h005, 2'd1, 1'b0, 32'h0, 1, 32'h0, 1'b1, 0);
    chk("mis_half_ceb", 32'(cap_ceb), 32'hF);
    chk("mis_half_we", 32'(cap_we), 32'h0);
    do_req("size3", 1'b1, 12'h008, 2'd3, 1'b0, 32'h12345678, 1, 32'h0, 1'b1, 0);
    chk("size3_ceb", 32'(cap_ceb), 32'hF);
    chk("size3_we", 32'(cap_we), 32'h0);
    do_req("mis_word", 1'b1, 12'h012, 2'd2, 1'b0, 32'hCAFEF00D, 1, 32'h0, 1'b1, 0);
    do_req("ld_after_mis", 1'b0, 12'h010, 2'd2, 1'b0, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);
    do_req("bp_load", 1'b0, 12'h010, 2'd2, 1'b0, 32'h0, 2, 32'hDEADBEEF, 1'b0, 5);

    // Reset while the load sits in RD_WAIT; the response must be dropped.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_wait_vld", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_vld", 32'(rsp_valid), 32'd0);
    chk("midrst_rdy", 32'(req_ready), 32'd0);
    chk("midrst_ceb", 32'(bank_ceb), 32'hF);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("postrst_rdy", 32'(req_ready), 32'd1);
    chk("postrst_ceb", 32'(bank_ceb), 32'hF);
    chk("postrst_vld", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst_vld2", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    do_req("ld_post_rst", 1'b0, 12'h020, 2'd0, 1'b0, 32'h0, 2, 32'h0, 1'b0, 0);
    do_req("ld_post_rst2", 1'b0, 12'h021, 2'd0, 1'b1, 32'h0, 2, 32'h0000005A, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Load/store front end between the CPU memory stage and the data memory: four byte-wide 1024-entry bank instances (lanes 0..3, 4 KB total).
- Accepts one byte-addressed load/store request at a time over a valid/ready handshake.
- Drives per-lane chip-enable, write-enable and address/data to the banks.
- Consumes the banks' registered read data and returns sign/zero-extended, right-aligned load data, or a write acknowledge, on a response handshake.

Parameters:
- ADDR_W, 12, byte address width; word index is addr[ADDR_W-1:2].
- BANK_AW, 10, bank address width; must equal ADDR_W-2.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  in  1  load zero-extends when 1
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  formatted load data; 0 for stores and errors
- rsp_err  out  1  misaligned or reserved-size request
- bank_ceb  out  4  per-lane chip enable, active-low
- bank_web  out  1  0 = write, 1 = read; common to all lanes
- bank_we  out  4  per-lane write enable
- bank_addr  out  BANK_AW  word index
- bank_wdata  out  32  lane n drives bits [8n+7:8n]
- bank_q  in  32  lane read data, valid the cycle after a read enable

Behaviour:
- Reset: resetn synchronous, active-low; clock clk.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 0 during reset.
- Bank outputs while idle or in reset: bank_ceb 4'hF, bank_web 1, bank_we 0, bank_addr 0, bank_wdata 0.
- Reset mid-operation: any in-flight request or pending response is dropped with no retry.
- States: IDLE, RD_WAIT, RESP.
- req_ready = 1 only in IDLE with resetn high.
- A request is accepted when req_valid & req_ready at a rising edge.
- Bank control is combinational from the request during the accept cycle, so each bank samples at that same edge.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0; size 3 is always an error.
- Lane mask: byte = 1<<addr[1:0]; half = 2'b11<<addr[1:0]; word = 4'hF.
- Store, aligned:
  - During the accept cycle: bank_web=0, bank_we=lane mask, bank_ceb=4'hF (no read), bank_addr=addr[11:2].
  - bank_wdata: byte replicated x4, half replicated x2, word as-is.
  - Next state RESP with rsp_err=0, rsp_rdata=0. Response appears 1 cycle after accept.
- Load, aligned:
  - During the accept cycle: bank_web=1, bank_ceb=~lane mask, bank_we=0.
  - Next state RD_WAIT. In RD_WAIT, bank_q is valid: shift right by 8*addr[1:0], then sign- or zero-extend per size/unsigned.
  - Register the result into rsp_rdata; go to RESP. Response appears 2 cycles after accept.
  - The latched addr[1:0], size and unsigned are held in registers across RD_WAIT.
- Error: no bank enable asserted; next state RESP with rsp_err=1, rsp_rdata=0.
- RESP: rsp_valid=1 and its data held stable until rsp_ready; then return to IDLE.
- No new request is accepted in the cycle rsp_ready is taken. Minimum request spacing is 2 cycles for stores and 3 for loads.
- rsp_ready asserted outside RESP is ignored.
- No combinational path from rsp_ready to req_ready.

Decomposition:
- Shared package: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state encoding, lane-mask function.
- One sub-module: dmem_load_align (combinational shift plus sign/zero extend).
- Store replication and lane mask stay inline.

Test Plan:
- Store word 0xDEADBEEF @0x010, then load word @0x010:
  - During the store accept cycle: bank_we=4'hF, bank_addr=4.
  - Store response: rsp_valid 1 cycle after accept, err=0.
  - Load response: rsp_rdata=0xDEADBEEF exactly 2 cycles after accept.
- Byte loads @0x013 after the word store:
  - Signed load -> 0xFFFFFFDE.
  - Unsigned load -> 0x000000DE.
  - Half load @0x012 signed -> 0xFFFFDEAD.
- Store byte 0x5A @0x021 over a word 0 -> bank_we=4'b0010; a following word load @0x020 returns 0x00005A00.
- Misaligned half @0x005 and size 3 @0x008:
  - No bank_ceb/bank_we activity.
  - rsp_err=1, rsp_rdata=0 one cycle after accept.
- Backpressure: hold rsp_ready=0 for 5 cycles on a load response.
  - rsp_valid and rsp_rdata stay stable; req_ready stays 0 while req_valid is held.
  - Exactly one response when rsp_ready rises.
- Reset mid-operation: resetn=0 in RD_WAIT -> next cycle IDLE outputs, rsp_valid 0; bank_ceb=4'hF after release.
